// File: rtl/fizzbuzz_pkg.sv
// rtl/fizzbuzz_pkg.sv - shared state encoding and reset defaults for fizzbuzz_sched
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_FIZZ_C = 3;
    localparam int DEF_BUZZ_C = 5;
    localparam int DEF_LEN_C  = 100;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - W-bit counter that wraps to zero after modulus-1
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] mod_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] mod_m1;

    assign mod_m1 = mod_i - W'(1);

    // next count: clear wins, then wrap at modulus-1 (>= guards a shrunk modulus)
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q >= mod_m1) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fizzbuzz_sched.sv
// rtl/fizzbuzz_sched.sv - configurable fizzbuzz result stream with handshake and abort
module fizzbuzz_sched
    import fizzbuzz_pkg::*;
#(
    parameter int W        = 8,
    parameter int DEF_FIZZ = DEF_FIZZ_C,
    parameter int DEF_BUZZ = DEF_BUZZ_C,
    parameter int DEF_LEN  = DEF_LEN_C
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_fizz,
    input  logic [W-1:0] cfg_buzz,
    input  logic [W-1:0] cfg_len,
    output logic         cfg_err,
    input  logic         start,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_fizz,
    output logic         out_buzz,
    output logic         out_fizzbuzz,
    output logic         busy,
    output logic         done
);

    state_t       state_q, state_d;
    logic [W-1:0] fizz_q, fizz_d;
    logic [W-1:0] buzz_q, buzz_d;
    logic [W-1:0] len_q, len_d;
    logic [W-1:0] idx_q, idx_d;
    logic         cfg_err_q, cfg_err_d;
    logic         cnt_clr;
    logic         cnt_en;
    logic [W-1:0] fizz_res;
    logic [W-1:0] buzz_res;
    logic         cfg_acc;
    logic         cfg_bad;
    logic         last_beat;
    logic         run_st;

    assign run_st    = (state_q == ST_RUN);
    assign cfg_acc   = cfg_valid && (state_q == ST_IDLE);
    assign cfg_bad   = (cfg_fizz == '0) || (cfg_buzz == '0) || (cfg_len == '0);
    assign last_beat = (idx_q == len_q - W'(1));

    // configuration: legal writes land on the accept edge, bad ones only raise the error pulse
    always_comb begin
        fizz_d    = fizz_q;
        buzz_d    = buzz_q;
        len_d     = len_q;
        cfg_err_d = 1'b0;
        if (cfg_acc) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                fizz_d = cfg_fizz;
                buzz_d = cfg_buzz;
                len_d  = cfg_len;
            end
        end
    end

    // sequencing FSM: start in IDLE, beat advance on handshake, abort overrides handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_q + W'(1);
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, index and configuration registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            fizz_q    <= W'(DEF_FIZZ);
            buzz_q    <= W'(DEF_BUZZ);
            len_q     <= W'(DEF_LEN);
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fizz_q    <= fizz_d;
            buzz_q    <= buzz_d;
            len_q     <= len_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    mod_counter #(.W(W)) u_fizz_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .mod_i  (fizz_q),
        .cnt_o  (fizz_res)
    );

    mod_counter #(.W(W)) u_buzz_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .mod_i  (buzz_q),
        .cnt_o  (buzz_res)
    );

    // flags are gated by RUN so idle residues of zero never show as hits
    assign out_valid    = run_st;
    assign out_idx      = idx_q;
    assign out_fizz     = run_st && (fizz_res == '0);
    assign out_buzz     = run_st && (buzz_res == '0);
    assign out_fizzbuzz = out_fizz && out_buzz;
    assign busy         = run_st;
    assign done         = (state_q == ST_DONE);
    assign cfg_ready    = (state_q == ST_IDLE);
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_fizzbuzz_sched.sv
// tb/tb_fizzbuzz_sched.sv - self-checking bench for fizzbuzz_sched
module tb_fizzbuzz_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_fizz;
    logic [W-1:0] cfg_buzz;
    logic [W-1:0] cfg_len;
    logic         cfg_err;
    logic         start;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_fizz;
    logic         out_buzz;
    logic         out_fizzbuzz;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    int m_fizz = 3;
    int m_buzz = 5;
    int m_len  = 100;

    typedef struct {
        int fizz;
        int buzz;
        int len;
        int exp_err;
        int mode;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    fizzbuzz_sched #(.W(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_fizz     (cfg_fizz),
        .cfg_buzz     (cfg_buzz),
        .cfg_len      (cfg_len),
        .cfg_err      (cfg_err),
        .start        (start),
        .abort        (abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_fizz     (out_fizz),
        .out_buzz     (out_buzz),
        .out_fizzbuzz (out_fizzbuzz),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
        chk({tag, " cfg_ready"}, cfg_ready, 1);
        chk({tag, " out_fizz"}, out_fizz, 0);
        chk({tag, " out_buzz"}, out_buzz, 0);
        chk({tag, " out_fizzbuzz"}, out_fizzbuzz, 0);
        chk({tag, " out_idx"}, out_idx, 0);
    endtask

    task automatic configure(input int f, input int b, input int l, input int exp_err);
        int fv = f;
        int bv = b;
        int lv = l;
        cfg_fizz  = fv[W-1:0];
        cfg_buzz  = bv[W-1:0];
        cfg_len   = lv[W-1:0];
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_err pulse", cfg_err, exp_err);
        if (exp_err == 0) begin
            m_fizz = f;
            m_buzz = b;
            m_len  = l;
        end
        @(negedge clk);
        chk("cfg_err one cycle", cfg_err, 0);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_beat(input int k);
        chk("out_valid", out_valid, 1);
        chk("busy", busy, 1);
        chk("done in run", done, 0);
        chk("out_idx", out_idx, k);
        chk("out_fizz", out_fizz, int'((k % m_fizz) == 0));
        chk("out_buzz", out_buzz, int'((k % m_buzz) == 0));
        chk("out_fizzbuzz", out_fizzbuzz, int'((k % m_fizz) == 0 && (k % m_buzz) == 0));
    endtask

    // mode 0: ready always, 1: ready toggles each cycle, else random
    task automatic check_beats(input int mode);
        int k   = 0;
        int cyc = 0;
        logic r;
        while (k < m_len && cyc < 8 * m_len + 50) begin
            check_beat(k);
            case (mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            @(negedge clk);
            out_ready = 1'b0;
            cyc++;
            if (r) k++;
        end
        chk("beat count", k, m_len);
        chk("done after last", done, 1);
        chk("out_valid in done", out_valid, 0);
        chk("busy in done", busy, 0);
        @(negedge clk);
        chk("done one cycle", done, 0);
        chk("cfg_ready back", cfg_ready, 1);
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            check_beat(i);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        resetn    = 1'b0;
        cfg_valid = 1'b0;
        cfg_fizz  = '0;
        cfg_buzz  = '0;
        cfg_len   = '0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{fizz: 2, buzz: 3, len: 7,  exp_err: 0, mode: 1};
        vecs[1] = '{fizz: 3, buzz: 0, len: 12, exp_err: 1, mode: 2};
        vecs[2] = '{fizz: 0, buzz: 4, len: 5,  exp_err: 1, mode: 2};
        vecs[3] = '{fizz: 1, buzz: 1, len: 1,  exp_err: 0, mode: 0};
        vecs[4] = '{fizz: 4, buzz: 6, len: 25, exp_err: 0, mode: 2};
        vecs[5] = '{fizz: 7, buzz: 1, len: 9,  exp_err: 0, mode: 2};
        vecs[6] = '{fizz: 5, buzz: 5, len: 0,  exp_err: 1, mode: 2};

        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after reset");

        // default run, ready held high
        start_run();
        check_beats(0);

        // configuration table, each followed by a run with the resulting config
        for (int i = 0; i < 7; i++) begin
            configure(vecs[i].fizz, vecs[i].buzz, vecs[i].len, vecs[i].exp_err);
            start_run();
            check_beats(vecs[i].mode);
        end

        // randomized legal configurations
        for (int i = 0; i < 6; i++) begin
            configure(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                      int'($urandom_range(1, 30)), 0);
            start_run();
            check_beats(2);
        end

        // configuration presented together with start is used by that run
        cfg_fizz  = 8'd3;
        cfg_buzz  = 8'd4;
        cfg_len   = 8'd10;
        cfg_valid = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        m_fizz = 3;
        m_buzz = 4;
        m_len  = 10;
        check_beats(2);

        // start and configuration during RUN are ignored
        configure(2, 3, 7, 0);
        start_run();
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_fizz  = 8'd9;
        cfg_buzz  = 8'd9;
        cfg_len   = 8'd9;
        chk("cfg_ready in run", cfg_ready, 0);
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b0;
        chk("start in run idx", out_idx, 0);
        chk("start in run busy", busy, 1);
        chk("cfg in run err", cfg_err, 0);
        check_beats(0);
        start_run();
        check_beats(1);

        // abort at idx 4 together with ready
        configure(6, 10, 30, 0);
        start_run();
        advance(4);
        check_beat(4);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort out_valid", out_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort cfg_ready", cfg_ready, 1);
        @(negedge clk);
        chk("abort no done", done, 0);
        start_run();
        check_beats(2);

        // reset mid-run beats abort, start, config and handshake
        configure(4, 6, 20, 0);
        start_run();
        advance(10);
        check_beat(10);
        resetn    = 1'b0;
        abort     = 1'b1;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_fizz  = 8'd2;
        cfg_buzz  = 8'd2;
        cfg_len   = 8'd2;
        out_ready = 1'b1;
        @(negedge clk);
        resetn    = 1'b1;
        abort     = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        out_ready = 1'b0;
        chk_idle_outputs("mid-run reset");
        m_fizz = 3;
        m_buzz = 5;
        m_len  = 100;
        @(negedge clk);
        start_run();
        check_beats(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fizzbuzz_sched.md
FIZZBUZZ_SCHED -- requirements
Module: fizzbuzz_sched

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the width of divisor, length and index fields.
REQ-002 The block SHALL have parameter DEF_FIZZ, default 3, meaning the fizz divisor loaded at reset.
REQ-003 The block SHALL have parameter DEF_BUZZ, default 5, meaning the buzz divisor loaded at reset.
REQ-004 The block SHALL have parameter DEF_LEN, default 100, meaning the sequence length loaded at reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_fizz / cfg_buzz / cfg_len (inputs, W each): the configuration handshake.
REQ-008 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected configuration.
REQ-009 The block SHALL have ports start (input, 1) and abort (input, 1): sequence control.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_idx (output, W), out_fizz, out_buzz, out_fizzbuzz (outputs, 1 each): the result stream.
REQ-011 The block SHALL have ports busy (output, 1) and done (output, 1): status.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 cfg_ready SHALL equal (state == IDLE); a configuration is accepted on cfg_valid && cfg_ready.
REQ-014 An accepted configuration with cfg_fizz == 0, cfg_buzz == 0 or cfg_len == 0 SHALL leave the config registers unchanged and pulse cfg_err the following cycle.
REQ-015 An accepted legal configuration SHALL update the fizz, buzz and length registers on that edge; the new values take effect for the next start.
REQ-016 In IDLE, start SHALL move the FSM to RUN on the next edge, clearing the index, fizz residue and buzz residue to 0; start in RUN or DONE SHALL be ignored.
REQ-017 When cfg_valid and start are both high in IDLE, the configuration SHALL be applied and the run SHALL use the new values.
REQ-018 In RUN, out_valid SHALL be 1; out_idx = index; out_fizz = (fizz residue == 0); out_buzz = (buzz residue == 0); out_fizzbuzz = out_fizz && out_buzz.
REQ-019 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-020 On out_valid && out_ready, when index != len-1, index SHALL increment and each residue SHALL increment, wrapping to 0 after divisor-1.
REQ-021 On out_valid && out_ready with index == len-1, the FSM SHALL enter DONE; DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-022 abort in RUN SHALL force IDLE on the next edge, overriding a simultaneous handshake; out_valid SHALL be 0 from that cycle and done SHALL not assert.
REQ-023 busy SHALL equal (state == RUN); out_valid SHALL be 0 outside RUN.
REQ-024 Divisor 1 SHALL be legal: the residue stays 0 and the corresponding flag is 1 on every beat.

Reset
REQ-025 With resetn low at an edge, state SHALL become IDLE, config registers SHALL become DEF_FIZZ/DEF_BUZZ/DEF_LEN, and index and residues SHALL become 0.
REQ-026 After reset: out_valid, busy, done and cfg_err SHALL be 0; cfg_ready SHALL be 1; the flag outputs SHALL be 0.
REQ-027 Reset asserted mid-run SHALL take precedence over abort, start, configuration and handshake, discarding the run.

Structure
REQ-028 Package fizzbuzz_pkg SHALL hold the state enum and the default divisor and length constants.
REQ-029 The residue counters SHALL be two instances of sub-module mod_counter (W-bit, modulus input, clear, enable, wrap to 0).

Verification
REQ-030 Reset, then start with defaults and out_ready=1 -> 100 beats; idx 0,3,6 have fizz=1; idx 0,5,10 have buzz=1; idx 0,15,30 have fizzbuzz=1; done pulses after idx 99.
REQ-031 Configure fizz=2, buzz=3, len=7, then start, with out_ready toggling every cycle -> idx 0..6, fizz on 0,2,4,6, buzz on 0,3,6, outputs stable while stalled, done after idx 6.
REQ-032 cfg_buzz=0 in IDLE -> cfg_err one-cycle pulse; a following run still uses the previous buzz divisor.
REQ-033 Abort asserted at idx 4 together with out_ready -> next cycle IDLE, out_valid=0, no done; a new start restarts at idx 0.
REQ-034 Assert resetn=0 at idx 10 -> next cycle all outputs at reset values and config registers back to 3/5/100.
REQ-035 Configure len=1, fizz=1 -> a single beat with idx 0 and all flags 1, followed by done; cfg_valid during RUN -> cfg_ready=0 and no change.
